// File: rtl/simon_uart_fsm_if.sv
// Handshake bundle between the SIMON UART sequencer, the UART pair and the cipher core.
// master = sequencer side, slave = UART/cipher side.
interface simon_uart_fsm_if;
  logic            [7:0] data_in;
  logic                  control_in;
  logic                  uart_tx_active;
  logic                  uart_tx_done;
  logic                  result_ready;
  logic [3:0][7:0]       crypt_out;
  logic                  control_out;
  logic            [7:0] data_out;
  logic                  cryp_decryp;
  logic [7:0][7:0]       k_in;
  logic [3:0][7:0]       text_in;
  logic                  led_input_commande;
  logic                  led_key_input;
  logic                  led_text_input;
  logic                  led_wait_result;
  logic                  led_output_result;

  modport master (
    input  data_in, control_in, uart_tx_active, uart_tx_done, result_ready, crypt_out,
    output control_out, data_out, cryp_decryp, k_in, text_in,
           led_input_commande, led_key_input, led_text_input, led_wait_result, led_output_result
  );

  modport slave (
    output data_in, control_in, uart_tx_active, uart_tx_done, result_ready, crypt_out,
    input  control_out, data_out, cryp_decryp, k_in, text_in,
           led_input_commande, led_key_input, led_text_input, led_wait_result, led_output_result
  );
endinterface

// File: rtl/simon_uart_fsm.sv
// Byte-serial sequencer: command, 8 key bytes, 4 text bytes in; 4 cipher result bytes out.
// Define CMD_CHECK_EN to accept only command bytes 0x00/0x01.
module simon_uart_fsm (
  input  logic            clk,
  input  logic            reset,
  simon_uart_fsm_if.master bus
);

  // One-hot encoding so each LED is a state flop.
  typedef enum logic [4:0] {
    S_CMD  = 5'b00001,
    S_KEY  = 5'b00010,
    S_TEXT = 5'b00100,
    S_WAIT = 5'b01000,
    S_OUT  = 5'b10000
  } state_t;

  state_t          state_q;
  logic            ctrl_in_q;
  logic [2:0]      cnt_q;
  logic            mode_q;
  logic [7:0][7:0] key_q;
  logic [3:0][7:0] text_q;
  logic [3:0][7:0] res_q;
  logic [7:0]      data_out_q;
  logic            ctrl_out_q;
  logic            sent_q;

  logic            byte_stb_d;
  logic [1:0]      idx_next_d;

  assign byte_stb_d = bus.control_in & ~ctrl_in_q;
  assign idx_next_d = cnt_q[1:0] + 2'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_CMD;
      ctrl_in_q  <= 1'b0;
      cnt_q      <= 3'd0;
      mode_q     <= 1'b0;
      key_q      <= '0;
      text_q     <= '0;
      res_q      <= '0;
      data_out_q <= 8'd0;
      ctrl_out_q <= 1'b0;
      sent_q     <= 1'b0;
    end else begin
      ctrl_in_q  <= bus.control_in;
      ctrl_out_q <= 1'b0;
      case (state_q)
        S_CMD: begin
          if (byte_stb_d) begin
`ifdef CMD_CHECK_EN
            if (bus.data_in[7:1] == 7'd0) begin
              mode_q  <= bus.data_in[0];
              cnt_q   <= 3'd0;
              state_q <= S_KEY;
            end
`else
            mode_q  <= bus.data_in[0];
            cnt_q   <= 3'd0;
            state_q <= S_KEY;
`endif
          end
        end
        S_KEY: begin
          if (byte_stb_d) begin
            key_q[cnt_q] <= bus.data_in;
            if (cnt_q == 3'd7) begin
              cnt_q   <= 3'd0;
              state_q <= S_TEXT;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        S_TEXT: begin
          if (byte_stb_d) begin
            text_q[cnt_q[1:0]] <= bus.data_in;
            if (cnt_q[1:0] == 2'd3) begin
              cnt_q   <= 3'd0;
              state_q <= S_WAIT;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        S_WAIT: begin
          if (bus.result_ready) begin
            res_q      <= bus.crypt_out;
            data_out_q <= bus.crypt_out[0];
            cnt_q      <= 3'd0;
            sent_q     <= 1'b0;
            state_q    <= S_OUT;
          end
        end
        S_OUT: begin
          // sent_q separates "waiting for idle transmitter" from "waiting for done".
          if (!sent_q) begin
            if (!bus.uart_tx_active) begin
              ctrl_out_q <= 1'b1;
              data_out_q <= res_q[cnt_q[1:0]];
              sent_q     <= 1'b1;
            end
          end else if (bus.uart_tx_done) begin
            sent_q <= 1'b0;
            if (cnt_q[1:0] == 2'd3) begin
              cnt_q   <= 3'd0;
              state_q <= S_CMD;
            end else begin
              cnt_q      <= cnt_q + 3'd1;
              data_out_q <= res_q[idx_next_d];
            end
          end
        end
        default: state_q <= S_CMD;
      endcase
    end
  end

  assign bus.control_out        = ctrl_out_q;
  assign bus.data_out           = data_out_q;
  assign bus.cryp_decryp        = mode_q;
  assign bus.k_in               = key_q;
  assign bus.text_in            = text_q;
  assign bus.led_input_commande = (state_q == S_CMD);
  assign bus.led_key_input      = (state_q == S_KEY);
  assign bus.led_text_input     = (state_q == S_TEXT);
  assign bus.led_wait_result    = (state_q == S_WAIT);
  assign bus.led_output_result  = (state_q == S_OUT);

endmodule

// File: tb/tb_simon_uart_fsm.sv
// Randomized scoreboard bench for simon_uart_fsm with UART transmitter and cipher stubs.
module tb_simon_uart_fsm;

  localparam logic [4:0] L_CMD  = 5'b00001;
  localparam logic [4:0] L_KEY  = 5'b00010;
  localparam logic [4:0] L_TEXT = 5'b00100;
  localparam logic [4:0] L_WAIT = 5'b01000;
  localparam logic [4:0] L_OUT  = 5'b10000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  simon_uart_fsm_if bus ();
  simon_uart_fsm dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // transmitter stub state
  logic stub_active = 1'b0;
  logic stub_done   = 1'b0;
  logic extra_busy  = 1'b0;
  logic spur_done   = 1'b0;
  int   stub_cnt    = 0;
  logic outstanding = 1'b0;
  logic [7:0] held_byte = 8'd0;
  int   tx_pulses   = 0;

  assign bus.uart_tx_active = stub_active | extra_busy;
  assign bus.uart_tx_done   = stub_done | spur_done;

  // reference model: what the sequencer should be holding
  logic [7:0] exp_k [8];
  logic [7:0] exp_t [4];
  logic       exp_mode;
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] leds();
    return {bus.led_output_result, bus.led_wait_result, bus.led_text_input,
            bus.led_key_input, bus.led_input_commande};
  endfunction

  // monitor + transmitter stub
  always @(negedge clk) begin
    if (reset) begin
      outstanding = 1'b0;
      stub_active = 1'b0;
      stub_done   = 1'b0;
      stub_cnt    = 0;
    end else begin
      stub_done = 1'b0;
      if (bus.control_out) begin
        tx_pulses++;
        chk("pulse_while_busy", {63'd0, bus.uart_tx_active}, 64'd0);
        chk("pulse_before_done", {63'd0, outstanding}, 64'd0);
        if (exp_q.size() == 0) chk("unexpected_pulse", 64'd1, 64'd0);
        else chk("tx_byte", {56'd0, bus.data_out}, {56'd0, exp_q.pop_front()});
        held_byte   = bus.data_out;
        outstanding = 1'b1;
        stub_active = 1'b1;
        stub_cnt    = $urandom_range(2, 6);
      end else if (outstanding && bus.data_out !== held_byte) begin
        chk("data_out_stable", {56'd0, bus.data_out}, {56'd0, held_byte});
      end
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          stub_done   = 1'b1;
          stub_active = 1'b0;
          outstanding = 1'b0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.data_in    = b;
    bus.control_in = 1'b1;
    @(negedge clk);
    bus.control_in = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) exp_k[i] = 8'd0;
    for (int i = 0; i < 4; i++) exp_t[i] = 8'd0;
    exp_mode = 1'b0;
  endtask

  task automatic check_regs(input string tag, input logic [4:0] exp_leds);
    chk({tag, "_leds"}, {59'd0, leds()}, {59'd0, exp_leds});
    chk({tag, "_mode"}, {63'd0, bus.cryp_decryp}, {63'd0, exp_mode});
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_key_word%0d", tag, i), {48'd0, bus.k_in[2*i+1], bus.k_in[2*i]},
          {48'd0, exp_k[2*i+1], exp_k[2*i]});
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s_text_word%0d", tag, i), {48'd0, bus.text_in[2*i+1], bus.text_in[2*i]},
          {48'd0, exp_t[2*i+1], exp_t[2*i]});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    clear_model();
    chk("reset_leds", {59'd0, leds()}, {59'd0, L_CMD});
    chk("reset_key", bus.k_in, 64'd0);
    chk("reset_text", {32'd0, bus.text_in}, 64'd0);
    chk("reset_txout", {55'd0, bus.control_out, bus.data_out}, 64'd0);
    chk("reset_mode", {63'd0, bus.cryp_decryp}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic [7:0] key [8], input logic [7:0] txt [4],
                         input logic [15:0] r0, input logic [15:0] r1, input bit busy);
    int n;
    int p0;
    send_byte(cmd);
    exp_mode = cmd[0];
    chk("cmd_state", {59'd0, leds()}, {59'd0, L_KEY});
    for (int i = 0; i < 8; i++) begin
      send_byte(key[i]);
      exp_k[i] = key[i];
    end
    chk("key_done_state", {59'd0, leds()}, {59'd0, L_TEXT});
    for (int i = 0; i < 4; i++) begin
      send_byte(txt[i]);
      exp_t[i] = txt[i];
    end
    check_regs("loaded", L_WAIT);
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    chk("spurious_done_ignored", {59'd0, leds()}, {59'd0, L_WAIT});
    p0 = tx_pulses;
    exp_q.push_back(r0[7:0]);
    exp_q.push_back(r0[15:8]);
    exp_q.push_back(r1[7:0]);
    exp_q.push_back(r1[15:8]);
    bus.crypt_out    = {r1[15:8], r1[7:0], r0[15:8], r0[7:0]};
    bus.result_ready = 1'b1;
    extra_busy       = busy;
    @(negedge clk);
    bus.result_ready = 1'b0;
    bus.crypt_out    = {$urandom()};
    chk("out_state", {59'd0, leds()}, {59'd0, L_OUT});
    if (busy) begin
      send_byte(8'h01);
      send_byte(8'h5A);
      chk("busy_no_pulse", tx_pulses - p0, 0);
      extra_busy = 1'b0;
    end
    n = 0;
    while (!bus.led_input_commande && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("return_timeout", {63'd0, (n >= 500)}, 64'd0);
    chk("tx_pulse_count", tx_pulses - p0, 4);
    chk("tx_queue_drained", exp_q.size(), 0);
    check_regs("after_out", L_CMD);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] key [8];
    logic [7:0] txt [4];
    logic [7:0] cmd;
    int p0;

    bus.data_in      = 8'd0;
    bus.control_in   = 1'b0;
    bus.result_ready = 1'b0;
    bus.crypt_out    = '0;
    clear_model();
    repeat (2) @(negedge clk);
    do_reset();

    p0 = tx_pulses;
    repeat (20) @(negedge clk);
    chk("idle_no_pulse", tx_pulses - p0, 0);
    check_regs("idle", L_CMD);

    key = '{8'h00, 8'h01, 8'h08, 8'h09, 8'h10, 8'h11, 8'h18, 8'h19};
    txt = '{8'h65, 8'h65, 8'h77, 8'h68};
    run_txn(8'h01, key, txt, 16'hc69b, 16'he9bb, 1'b1);
    chk("enc_key_word0", {48'd0, bus.k_in[1], bus.k_in[0]}, 64'h0100);
    chk("enc_key_word3", {48'd0, bus.k_in[7], bus.k_in[6]}, 64'h1918);
    chk("enc_text_word1", {48'd0, bus.text_in[3], bus.text_in[2]}, 64'h6877);

    for (int t = 0; t < 6; t++) begin
`ifdef CMD_CHECK_EN
      cmd = 8'($urandom_range(0, 1));
`else
      cmd = 8'($urandom());
`endif
      for (int i = 0; i < 8; i++) key[i] = 8'($urandom());
      for (int i = 0; i < 4; i++) txt[i] = 8'($urandom());
      run_txn(cmd, key, txt, 16'($urandom()), 16'($urandom()), (t % 2) == 1);
    end

    // held strobe: one byte per rising edge
    send_byte(8'h01);
    exp_mode = 1'b1;
    @(negedge clk);
    spur_done      = 1'b1;
    bus.data_in    = 8'hA5;
    bus.control_in = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (4) @(negedge clk);
    bus.control_in = 1'b0;
    @(negedge clk);
    exp_k[0] = 8'hA5;
    check_regs("held", L_KEY);
    send_byte(8'h3C);
    exp_k[1] = 8'h3C;
    send_byte(8'h77);
    exp_k[2] = 8'h77;
    check_regs("three_keys", L_KEY);
    do_reset();

`ifdef CMD_CHECK_EN
    send_byte(8'h7F);
    check_regs("bad_cmd", L_CMD);
    send_byte(8'h00);
    exp_mode = 1'b0;
    check_regs("good_cmd", L_KEY);
`else
    send_byte(8'hFF);
    exp_mode = 1'b1;
    check_regs("any_cmd", L_KEY);
`endif
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_uart_fsm.md
# simon_uart_fsm

Byte-serial control sequencer between a UART receiver/transmitter pair and a SIMON32/64 cipher core. It collects a command byte, an 8-byte key and a 4-byte text block from the receiver, then drives the cipher's key, text and mode inputs. It holds the cipher in its run phase until the result is ready and streams the 4 result bytes out through the UART transmitter handshake.

## Interface
- No parameters. Byte widths, key length (8 bytes) and block length (4 bytes) are fixed.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  8  received UART byte; valid while control_in is high.
- control_in  in  1  receive-byte strobe.
- uart_tx_active  in  1  transmitter busy.
- uart_tx_done  in  1  transmitter one-cycle byte-complete pulse.
- result_ready  in  1  cipher done flag.
- crypt_out  in  4x8  cipher result bytes, index 0 = least significant byte of word 0.
- control_out  out  1  one-cycle transmit start pulse.
- data_out  out  8  byte presented to the transmitter.
- cryp_decryp  out  1  cipher mode: 1 = encrypt, 0 = decrypt.
- k_in  out  8x8  key bytes; the cipher word k[i] = {k_in[2i+1], k_in[2i]}.
- text_in  out  4x8  text bytes; the cipher word t[i] = {text_in[2i+1], text_in[2i]}.
- led_input_commande, led_key_input, led_text_input, led_wait_result, led_output_result  out  1 each
  - One-hot state indicators.
  - led_wait_result also serves as the cipher run enable; the cipher waits while this signal is low.

## Operation
- States: INPUT_COMMANDE → KEY_INPUT → TEXT_INPUT → WAIT_RESULT → OUTPUT_RESULT → INPUT_COMMANDE. Exactly one LED is high, matching the current state.
- Byte acceptance:
  - A byte is accepted on a rising edge of control_in, detected against a registered copy of control_in.
  - If control_in stays high for several cycles, one byte is accepted.
  - Bytes are accepted only in INPUT_COMMANDE, KEY_INPUT and TEXT_INPUT and are ignored in all other states.
- INPUT_COMMANDE: an accepted byte sets cryp_decryp = data_in[0], clears the byte counter and moves to KEY_INPUT.
- KEY_INPUT: the n-th accepted byte (n = 0..7) is stored into k_in[n]. After byte 7 the counter clears and the state moves to TEXT_INPUT.
- TEXT_INPUT: the n-th accepted byte (n = 0..3) is stored into text_in[n]. After byte 3 the state moves to WAIT_RESULT.
- WAIT_RESULT: when result_ready is high, all 4 crypt_out bytes are latched into an internal result register and the state moves to OUTPUT_RESULT. The result_ready level is sampled only in this state.
- OUTPUT_RESULT: result bytes are sent in order index 0,1,2,3.
  - For each byte: data_out is driven with the byte, then control_out pulses high for one cycle, but only while uart_tx_active is low.
  - The block then waits for uart_tx_done before moving to the next byte.
  - After the done pulse of byte 3 the state returns to INPUT_COMMANDE.
- k_in, text_in and cryp_decryp hold their values until they are overwritten by the next transaction.

## Timing
- Reset values:
  - State INPUT_COMMANDE, led_input_commande = 1, all other LEDs = 0.
  - k_in, text_in, data_out, control_out, cryp_decryp and the counter = 0.
- Byte capture: the stored byte and any state change are visible one cycle after the clk edge that samples control_in rising.
- Capture rate: back-to-back bytes spaced 2 cycles apart (high 1 cycle, low 1 cycle) are all captured.
- Entry to WAIT_RESULT happens the cycle after the 4th text byte is captured.
- The first control_out pulse comes 1 cycle after entering OUTPUT_RESULT, provided the transmitter is idle.
- data_out stays stable from the start pulse until uart_tx_done.
- uart_tx_done arriving in any state other than OUTPUT_RESULT is ignored.
- A reset assertion in any state aborts the transaction immediately and restores all reset values; partially received keys are discarded.

## Configuration
- CMD_CHECK_EN defined:
  - In INPUT_COMMANDE, only command bytes 0x00 and 0x01 are accepted.
  - Any other byte is dropped; the state stays in INPUT_COMMANDE and cryp_decryp is unchanged.
- CMD_CHECK_EN undefined: any byte is accepted as a command and only bit 0 is used.

## Test plan
- Reset, then idle → led_input_commande = 1, all other outputs 0, control_out never pulses.
- Encrypt flow:
  - Stimulus: command 0x01; key bytes 00,01,08,09,10,11,18,19; text bytes 65,65,77,68.
  - Required: cryp_decryp = 1, key words {0100, 0908, 1110, 1918}, text words {6565, 6877}, led_wait_result = 1 after the last text byte.
- Result output:
  - Stimulus: a cipher stub asserts result_ready with result words {c69b, e9bb}.
  - Required: the transmitter receives 9b, c6, bb, e9 in order, one control_out pulse per byte, each pulse only after the previous uart_tx_done; the state then returns to INPUT_COMMANDE.
- control_in held high for 5 cycles during KEY_INPUT → exactly one byte stored, counter advances by 1.
- reset asserted after 3 key bytes → immediate INPUT_COMMANDE; k_in all 0.
- With CMD_CHECK_EN defined, command 0x7F → stays in INPUT_COMMANDE; a following command 0x00 → KEY_INPUT with cryp_decryp = 0.
